alu_mdu_control: RTL
====================

Name: alu_mdu_control

Overview:
- Parametrised successor to the single-cycle ALU decoder: combinational ALU-control decode plus an iterative multiply/divide unit (MDU) with HI/LO registers and a stall handshake.
- Sits between the main control unit and the ALU/register-file write-back mux of the MIPS datapath.
- Unsupported funct codes raise a registered illegal flag.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, ≥4.
- CTRL_W, 3, alu_control width; ≥3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- alu_op  in  2  from main control (00 add, 01 sub, 10 R-type, 11 reserved).
- funct  in  6  instruction[5:0].
- instr_valid  in  1  current instruction is real (not a bubble); qualifies all MDU and illegal actions.
- src_a  in  WIDTH  rs value; dividend / multiplicand / MTHI-MTLO data.
- src_b  in  WIDTH  rt value; divisor / multiplier.
- alu_control  out  CTRL_W  ALU operation, combinational.
- mdu_result  out  WIDTH  HI for MFHI, LO for MFLO, else 0; combinational.
- mdu_sel  out  1  write-back selects mdu_result (MFHI/MFLO decoded).
- stall  out  1  hold PC/pipeline this cycle; combinational.
- busy  out  1  MDU iterating.
- done  out  1  one-cycle pulse; HI/LO updated this cycle.
- illegal  out  1  registered; 1 cycle after an undecoded R-type funct.
- hi, lo  out  WIDTH each  architectural HI/LO.

Behaviour:
- Decode, combinational:
  - alu_op 00 -> 010; 01 -> 100; 11 -> 010.
  - alu_op 10 by funct: 100000 -> 010; 100010 -> 100; 101010 -> 110; 011100 -> 101; 100100 -> 000; 100101 -> 001.
  - Any other funct -> 010, no simulation messages.
  - Upper CTRL_W-3 bits are zero.
- MDU ops (alu_op 10 only): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011. These are legal and drive alu_control 010.
- illegal: registered each cycle = instr_valid & alu_op==10 & funct not in the decode or MDU lists.
- FSM states IDLE, RUN, FIN:
  - IDLE -> RUN on an accepted start (instr_valid & MULT/MULTU/DIV/DIVU & state==IDLE). On acceptance, latch the op, operand magnitudes (signed ops use |x|), result-sign flags; iteration counter = 0.
  - RUN: one bit per cycle; shift-add for multiply, restoring shift-subtract for divide. Counter increments; after WIDTH RUN cycles -> FIN.
  - FIN: apply sign correction (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa), write HI/LO, done=1, -> IDLE.
- Latency:
  - Start accepted at edge N; busy high for cycles N+1..N+WIDTH.
  - done and new HI/LO visible in cycle N+WIDTH+1.
  - Next start accepted at edge N+WIDTH+2.
- Results:
  - MULT/MULTU: {hi, lo} = 2·WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero: runs full latency; lo = all ones, hi = src_a as latched (raw, sign untouched).
- Signed MIN / -1: lo = MIN, hi = 0. This falls out of the magnitude algorithm and needs no special case.
- MTHI/MTLO in IDLE: hi/lo <= src_a at the next edge.
- stall = instr_valid & state!=IDLE & (any MDU op).
  - The stalled instruction has no effect and is re-presented next cycle.
  - MFHI/MFLO are blocked until state==IDLE, so they always read completed results.
- Outputs are combinational from current state, so no hazard bypass is needed.
- Reset, including mid-operation: state IDLE, hi=lo=0, busy=done=illegal=0, counter=0, operation abandoned.
  - stall, mdu_sel and mdu_result follow the combinational rules with hi=lo=0.

Test Plan:
- Decode sweep: alu_op 00/01/11 and every listed funct with alu_op 10 -> exact alu_control values. funct 111111 with instr_valid -> alu_control 010, illegal=1 next cycle. Same funct with instr_valid=0 -> illegal=0.
- MULT with src_a=0xFFFFFFFE, src_b=3 -> done exactly 33 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV:
  - -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Hazard: MFLO presented the cycle after a MULT start -> stall=1 for 33 cycles. MFLO then returns the new lo with mdu_sel=1. A second MULT presented while busy -> stall, no restart.
- MTHI 0x12345678 then MFHI in IDLE -> mdu_result=0x12345678, no stall.
- Reset asserted asynchronously at RUN cycle 10 -> busy/done/hi/lo=0 immediately. A fresh DIVU 100/7 afterwards -> lo=14, hi=2.

Source files
------------

// File: rtl/alu_mdu_control.sv
// ALU control decode plus iterative multiply/divide unit with HI/LO.
// Stall handshake holds the pipeline while the MDU is not idle.
module alu_mdu_control #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [WIDTH-1:0]  mdu_result,
  output logic              mdu_sel,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MUL   = 6'b011100;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_n;

  logic       rtype;
  logic [2:0] ctl;
  logic       legal;
  logic       md_start;
  logic       md_any;
  logic       is_mfhi;
  logic       is_mflo;
  logic       is_mthi;
  logic       is_mtlo;

  assign rtype = (alu_op == 2'b10);

  always_comb begin
    ctl      = 3'b010;
    legal    = 1'b1;
    md_start = 1'b0;
    md_any   = 1'b0;
    is_mfhi  = 1'b0;
    is_mflo  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    unique case (1'b1)
      (alu_op == 2'b01): ctl = 3'b100;
      rtype: begin
        case (funct)
          F_ADD: ctl = 3'b010;
          F_SUB: ctl = 3'b100;
          F_SLT: ctl = 3'b110;
          F_MUL: ctl = 3'b101;
          F_AND: ctl = 3'b000;
          F_OR:  ctl = 3'b001;
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            md_start = 1'b1;
            md_any   = 1'b1;
          end
          F_MFHI: begin
            is_mfhi = 1'b1;
            md_any  = 1'b1;
          end
          F_MFLO: begin
            is_mflo = 1'b1;
            md_any  = 1'b1;
          end
          F_MTHI: begin
            is_mthi = 1'b1;
            md_any  = 1'b1;
          end
          F_MTLO: begin
            is_mtlo = 1'b1;
            md_any  = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: ctl = 3'b010;
    endcase
  end

  logic start;

  assign alu_control = CTRL_W'(ctl);
  assign start       = instr_valid & md_start & (state == IDLE);
  assign stall       = instr_valid & (state != IDLE) & md_any;
  assign mdu_sel     = is_mfhi | is_mflo;
  assign mdu_result  = is_mfhi ? hi : (is_mflo ? lo : '0);

  // Signed ops iterate on magnitudes; signs are restored at the end.
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sgn   = ~funct[0];
  assign a_neg = sgn & src_a[WIDTH-1];
  assign b_neg = sgn & src_b[WIDTH-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] op_b;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       sh;
  logic [1:0]           brw;
  logic [WIDTH-1:0]     dif;
  logic                 ge;
  logic [WIDTH-1:0]     n_hi;
  logic [WIDTH-1:0]     n_lo;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_c;
  logic [WIDTH-1:0]     q_c;
  logic [WIDTH-1:0]     r_c;
  logic                 last;

  always_comb begin
    sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, op_b} : '0);
    sh  = {w_hi, w_lo[WIDTH-1]};
    {brw, dif} = {1'b0, sh} - {2'b00, op_b};
    ge  = (brw == 2'b00);
    if (is_div) begin
      n_hi = ge ? dif : sh[WIDTH-1:0];
      n_lo = {w_lo[WIDTH-2:0], ge};
    end else begin
      n_hi = sum[WIDTH:1];
      n_lo = {sum[0], w_lo[WIDTH-1:1]};
    end
    prod   = {n_hi, n_lo};
    prod_c = neg_q ? -prod : prod;
    q_c    = dz ? '1 : (neg_q ? -n_lo : n_lo);
    r_c    = neg_r ? -n_hi : n_hi;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_hi   <= '0;
      w_lo   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      is_div <= funct[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= funct[1] & a_neg;
      dz     <= funct[1] & (src_b == '0);
      w_hi   <= '0;
      w_lo   <= funct[1] ? mag_a : mag_b;
      op_b   <= funct[1] ? mag_b : mag_a;
      cnt    <= '0;
    end else if (state == RUN) begin
      w_hi <= n_hi;
      w_lo <= n_lo;
      cnt  <= cnt + CW'(1);
      // Final step lands corrected results so FIN already shows them.
      if (last) begin
        if (is_div) begin
          hi <= r_c;
          lo <= q_c;
        end else begin
          {hi, lo} <= prod_c;
        end
      end
    end else if (state == IDLE && instr_valid) begin
      if (is_mthi) hi <= src_a;
      if (is_mtlo) lo <= src_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= instr_valid & rtype & ~legal;
  end

endmodule
